pcs_tx_code_group: RTL and testbench
====================================

PCS_TX_CODE_GROUP -- requirements
Module: pcs_tx_code_group

Interface
REQ-001 GTX_CLK  input  1  sole clock; all state updates on rising edge.
REQ-002 mr_main_reset  input  1  synchronous, active-high reset.
REQ-003 tx_o_set  input  3  ordered-set request from upstream TRANSMIT: 000 /I/, 001 /D/, 010 /S/, 011 /T/, 100 /R/, 101 /V/; 110/111 treated as /V/.
REQ-004 TXD  input  8  data octet (HGFEDCBA), used only with /D/.
REQ-005 tx_code_group  output  10  registered 8B/10B code-group; bit 9 = a (first transmitted) ... bit 0 = j.
REQ-006 tx_even  output  1  high when the current tx_code_group occupies an even slot.
REQ-007 TX_OSET_indicate  output  1  high when the current code-group is the last of its ordered set; upstream inputs sampled at this cycle's closing edge.
REQ-008 tx_disparity  output  1  running disparity after the current code-group; 0 = negative, 1 = positive.

Function
REQ-009 All outputs SHALL be registered; latency from sampling tx_o_set/TXD to first resulting code-group SHALL be exactly 1 cycle.
REQ-010 tx_o_set and TXD SHALL be sampled only at edges where TX_OSET_indicate = 1 and ignored otherwise.
REQ-011 tx_even SHALL toggle every cycle outside reset.
REQ-012 State machine: GEN (single code-group sets), IDLE_K (K28.5 slot), IDLE_D (second /I/ slot), ALIGN (/R/ pad).
REQ-013 /D/ SHALL emit Dx.y for TXD; /S/ K27.7; /T/ K29.7; /R/ K23.7; /V/ K30.7; one slot each, TX_OSET_indicate = 1.
REQ-014 /I/ requested for an even next slot SHALL enter IDLE_K: emit K28.5 with TX_OSET_indicate = 0, then IDLE_D with TX_OSET_indicate = 1.
REQ-015 In IDLE_D, if tx_disparity after K28.5 is positive, emit D16.2 (/I2/); if negative, emit D5.6 (/I1/), restoring negative disparity.
REQ-016 /I/ requested for an odd next slot SHALL enter ALIGN: emit K23.7 with TX_OSET_indicate = 0, then IDLE_K/IDLE_D on the following even slot without resampling.
REQ-017 Encoding SHALL follow the 5b/6b + 3b/4b tables with disparity selected per sub-block, including the alternate A7 (x.P7) for D17/D18/D20 at RD- and D11/D13/D14 at RD+.
REQ-018 tx_disparity SHALL update each cycle from the emitted code-group; neutral code-groups leave it unchanged.
REQ-019 K code-groups other than K28.5, K23.7, K27.7, K29.7, K30.7 SHALL never be emitted.

Reset
REQ-020 While mr_main_reset = 1 at an edge: tx_code_group = K28.5 RD- (0011111010), tx_even = 1, TX_OSET_indicate = 0, tx_disparity = 1 (after K28.5), state IDLE_D.
REQ-021 On the first edge after deassertion, the block SHALL emit D16.2 (1001000101), tx_even = 0, TX_OSET_indicate = 1, tx_disparity = 0.
REQ-022 Reset asserted mid-set (IDLE_D or ALIGN) SHALL abandon the set and take REQ-020 values at that edge.

Verification
REQ-023 Reset then tx_o_set = /I/ held -> repeating 0011111010, 1001000101; tx_even 1,0; TX_OSET_indicate 0,1; tx_disparity 1,0.
REQ-024 After /I/, /S/ then /D/ TXD = 8'h00 then /T/ at RD- -> 1101101000, 1001110100, 1011101000; TX_OSET_indicate 1 each; tx_disparity 0 throughout.
REQ-025 /D/ TXD = 8'h20 (D0.1) at RD- -> 1001111001, tx_disparity 1; next /I/ on even slot -> 1100000101, 1010010110, tx_disparity 0.
REQ-026 /I/ sampled with odd next slot -> 1110101000 with TX_OSET_indicate = 0, then K28.5 with tx_even = 1, then /I2/ or /I1/ per REQ-015.
REQ-027 Reset pulse in IDLE_D slot -> outputs per REQ-020 at that edge, then REQ-021 sequence.
REQ-028 tx_o_set = 3'b111 at RD- -> 0111101000 (K30.7), identical to /V/.

Source files
------------

// File: rtl/pcs_tx_code_group.sv
// 1000BASE-X PCS transmit code-group generator: turns ordered-set requests into
// registered 8B/10B code-groups and tracks running disparity and slot parity.
module pcs_tx_code_group (
    input  logic       GTX_CLK,
    input  logic       mr_main_reset,
    input  logic [2:0] tx_o_set,
    input  logic [7:0] TXD,
    output logic [9:0] tx_code_group,
    output logic       tx_even,
    output logic       TX_OSET_indicate,
    output logic       tx_disparity
);
    // Handshake: tx_o_set/TXD are consumed at a rising edge only when
    // TX_OSET_indicate is high; otherwise they are ignored that cycle.

    // state names the role of the code-group currently on tx_code_group
    typedef enum logic [1:0] {GEN, IDLE_K, IDLE_D, ALIGN} state_t;
    state_t state;

    localparam logic [9:0] K28_5 = 10'b0011111010;
    localparam logic [9:0] K23_7 = 10'b1110101000;
    localparam logic [9:0] K27_7 = 10'b1101101000;
    localparam logic [9:0] K29_7 = 10'b1011101000;
    localparam logic [9:0] K30_7 = 10'b0111101000;
    localparam logic [7:0] D16_2 = 8'h50;
    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [1:0] UNB   = 2'b11;
    localparam logic [1:0] NEU   = 2'b00;
    localparam logic [1:0] ALT   = 2'b10;

    // Returns {rd_after, abcdeifghj}. Tables hold the RD- form; {comp, flip}
    // says whether the RD+ form is the complement and whether disparity flips.
    function automatic logic [10:0] enc_data(input logic [7:0] d, input logic rd);
        logic [4:0] x;
        logic [2:0] y;
        logic       comp6, flip6, comp4, flip4, rd_mid, a7;
        logic [5:0] t6;
        logic [3:0] t4;
        x = d[4:0];
        y = d[7:5];
        {comp6, flip6, t6} = '0;
        case (x)
            5'd0:  {comp6, flip6, t6} = {UNB, 6'b100111};
            5'd1:  {comp6, flip6, t6} = {UNB, 6'b011101};
            5'd2:  {comp6, flip6, t6} = {UNB, 6'b101101};
            5'd3:  {comp6, flip6, t6} = {NEU, 6'b110001};
            5'd4:  {comp6, flip6, t6} = {UNB, 6'b110101};
            5'd5:  {comp6, flip6, t6} = {NEU, 6'b101001};
            5'd6:  {comp6, flip6, t6} = {NEU, 6'b011001};
            5'd7:  {comp6, flip6, t6} = {ALT, 6'b111000};
            5'd8:  {comp6, flip6, t6} = {UNB, 6'b111001};
            5'd9:  {comp6, flip6, t6} = {NEU, 6'b100101};
            5'd10: {comp6, flip6, t6} = {NEU, 6'b010101};
            5'd11: {comp6, flip6, t6} = {NEU, 6'b110100};
            5'd12: {comp6, flip6, t6} = {NEU, 6'b001101};
            5'd13: {comp6, flip6, t6} = {NEU, 6'b101100};
            5'd14: {comp6, flip6, t6} = {NEU, 6'b011100};
            5'd15: {comp6, flip6, t6} = {UNB, 6'b010111};
            5'd16: {comp6, flip6, t6} = {UNB, 6'b011011};
            5'd17: {comp6, flip6, t6} = {NEU, 6'b100011};
            5'd18: {comp6, flip6, t6} = {NEU, 6'b010011};
            5'd19: {comp6, flip6, t6} = {NEU, 6'b110010};
            5'd20: {comp6, flip6, t6} = {NEU, 6'b001011};
            5'd21: {comp6, flip6, t6} = {NEU, 6'b101010};
            5'd22: {comp6, flip6, t6} = {NEU, 6'b011010};
            5'd23: {comp6, flip6, t6} = {UNB, 6'b111010};
            5'd24: {comp6, flip6, t6} = {UNB, 6'b110011};
            5'd25: {comp6, flip6, t6} = {NEU, 6'b100110};
            5'd26: {comp6, flip6, t6} = {NEU, 6'b010110};
            5'd27: {comp6, flip6, t6} = {UNB, 6'b110110};
            5'd28: {comp6, flip6, t6} = {NEU, 6'b001110};
            5'd29: {comp6, flip6, t6} = {UNB, 6'b101110};
            5'd30: {comp6, flip6, t6} = {UNB, 6'b011110};
            5'd31: {comp6, flip6, t6} = {UNB, 6'b101011};
        endcase
        rd_mid = rd ^ flip6;
        {comp4, flip4, t4} = '0;
        case (y)
            3'd0: {comp4, flip4, t4} = {UNB, 4'b1011};
            3'd1: {comp4, flip4, t4} = {NEU, 4'b1001};
            3'd2: {comp4, flip4, t4} = {NEU, 4'b0101};
            3'd3: {comp4, flip4, t4} = {ALT, 4'b1100};
            3'd4: {comp4, flip4, t4} = {UNB, 4'b1101};
            3'd5: {comp4, flip4, t4} = {NEU, 4'b1010};
            3'd6: {comp4, flip4, t4} = {NEU, 4'b0110};
            3'd7: {comp4, flip4, t4} = {UNB, 4'b1110};
        endcase
        // A7 avoids a run of five equal bits across the sub-block boundary
        a7 = (y == 3'd7) && (rd_mid ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                                    : (x == 5'd17 || x == 5'd18 || x == 5'd20));
        if (a7) t4 = 4'b0111;
        return {rd_mid ^ flip4,
                (rd & comp6) ? ~t6 : t6,
                (rd_mid & comp4) ? ~t4 : t4};
    endfunction

    function automatic logic [10:0] enc_k(input logic [9:0] k_neg, input logic flips,
                                          input logic rd);
        return {rd ^ flips, rd ? ~k_neg : k_neg};
    endfunction

    always_ff @(posedge GTX_CLK) begin
        if (mr_main_reset) begin
            tx_code_group    <= K28_5;
            tx_even          <= 1'b1;
            TX_OSET_indicate <= 1'b0;
            tx_disparity     <= 1'b1;
            state            <= IDLE_K;
        end else begin
            tx_even <= ~tx_even;
            case (state)
                IDLE_K: begin
                    {tx_disparity, tx_code_group} <=
                        enc_data(tx_disparity ? D16_2 : D5_6, tx_disparity);
                    TX_OSET_indicate <= 1'b1;
                    state            <= IDLE_D;
                end
                ALIGN: begin
                    {tx_disparity, tx_code_group} <= enc_k(K28_5, 1'b1, tx_disparity);
                    TX_OSET_indicate <= 1'b0;
                    state            <= IDLE_K;
                end
                default: begin
                    TX_OSET_indicate <= (tx_o_set != 3'b000);
                    state            <= GEN;
                    case (tx_o_set)
                        3'b000: begin
                            // next slot is even when the current one is odd
                            if (!tx_even) begin
                                {tx_disparity, tx_code_group} <= enc_k(K28_5, 1'b1, tx_disparity);
                                state <= IDLE_K;
                            end else begin
                                {tx_disparity, tx_code_group} <= enc_k(K23_7, 1'b0, tx_disparity);
                                state <= ALIGN;
                            end
                        end
                        3'b001: {tx_disparity, tx_code_group} <= enc_data(TXD, tx_disparity);
                        3'b010: {tx_disparity, tx_code_group} <= enc_k(K27_7, 1'b0, tx_disparity);
                        3'b011: {tx_disparity, tx_code_group} <= enc_k(K29_7, 1'b0, tx_disparity);
                        3'b100: {tx_disparity, tx_code_group} <= enc_k(K23_7, 1'b0, tx_disparity);
                        default: {tx_disparity, tx_code_group} <= enc_k(K30_7, 1'b0, tx_disparity);
                    endcase
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pcs_tx_code_group.sv
// Bench for pcs_tx_code_group: directed ordered-set sequences plus random
// requests, all compared against a queue-based ordered-set model.
module tb_pcs_tx_code_group;
    logic       GTX_CLK = 1'b0;
    logic       mr_main_reset;
    logic [2:0] tx_o_set;
    logic [7:0] TXD;
    logic [9:0] tx_code_group;
    logic       tx_even;
    logic       TX_OSET_indicate;
    logic       tx_disparity;

    int n_tests = 0;
    int n_fail  = 0;
    logic [12:0] exp_q[$];

    // ---------------- clock ----------------
    always #5 GTX_CLK = ~GTX_CLK;

    pcs_tx_code_group dut (
        .GTX_CLK          (GTX_CLK),
        .mr_main_reset    (mr_main_reset),
        .tx_o_set         (tx_o_set),
        .TXD              (TXD),
        .tx_code_group    (tx_code_group),
        .tx_even          (tx_even),
        .TX_OSET_indicate (TX_OSET_indicate),
        .tx_disparity     (tx_disparity)
    );

    // ---------------- reference model ----------------
    localparam int SYM_K28_5 = 256;
    localparam int SYM_K23_7 = 257;
    localparam int SYM_K27_7 = 258;
    localparam int SYM_K29_7 = 259;
    localparam int SYM_K30_7 = 260;
    localparam int SYM_IDLE  = 261;

    // RD- forms, indexed by the 5-bit / 3-bit sub-block value
    logic [5:0] t6 [0:31] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    logic [3:0] t4 [0:7] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                             4'b1101, 4'b1010, 4'b0110, 4'b1110};

    function automatic logic [9:0] k_neg(input int s);
        case (s)
            SYM_K28_5: return 10'b0011111010;
            SYM_K23_7: return 10'b1110101000;
            SYM_K27_7: return 10'b1101101000;
            SYM_K29_7: return 10'b1011101000;
            default:   return 10'b0111101000;
        endcase
    endfunction

    // {rd_after, code}; sub-block choice and disparity derived from bit counts
    function automatic logic [10:0] model_encode(input int sym, input logic rd);
        logic [9:0] c;
        logic [7:0] d;
        logic [5:0] c6;
        logic [3:0] c4;
        logic       rd_mid;
        int         n, x, y;
        if (sym >= 256) begin
            c = k_neg(sym);
            if (rd) c = ~c;
        end else begin
            d = sym[7:0];
            x = int'(d[4:0]);
            y = int'(d[7:5]);
            c6 = t6[x];
            if (rd && ($countones(c6) != 3 || x == 7)) c6 = ~c6;
            n = $countones(c6);
            rd_mid = (n > 3) ? 1'b1 : (n < 3) ? 1'b0 : rd;
            c4 = t4[y];
            if (y == 7 && ((!rd_mid && (x == 17 || x == 18 || x == 20)) ||
                           (rd_mid && (x == 11 || x == 13 || x == 14))))
                c4 = 4'b0111;
            if (rd_mid && ($countones(c4) != 2 || y == 3 || y == 7)) c4 = ~c4;
            c = {c6, c4};
        end
        n = $countones(c);
        return {(n > 5) ? 1'b1 : (n < 5) ? 1'b0 : rd, c};
    endfunction

    int   pend[$];
    logic m_rd, m_even;

    task automatic model_step();
        int         sym;
        logic [10:0] e;
        if (mr_main_reset) begin
            pend.delete();
            pend.push_back(SYM_IDLE);
            m_rd   = 1'b1;
            m_even = 1'b1;
            exp_q.push_back({10'b0011111010, 1'b1, 1'b0, 1'b1});
        end else begin
            if (pend.size() == 0) begin
                case (tx_o_set)
                    3'd0: begin
                        if (m_even) pend.push_back(SYM_K23_7);
                        pend.push_back(SYM_K28_5);
                        pend.push_back(SYM_IDLE);
                    end
                    3'd1:    pend.push_back(int'(TXD));
                    3'd2:    pend.push_back(SYM_K27_7);
                    3'd3:    pend.push_back(SYM_K29_7);
                    3'd4:    pend.push_back(SYM_K23_7);
                    default: pend.push_back(SYM_K30_7);
                endcase
            end
            sym = pend.pop_front();
            if (sym == SYM_IDLE) sym = m_rd ? 'h50 : 'hC5;
            e = model_encode(sym, m_rd);
            m_rd   = e[10];
            m_even = ~m_even;
            exp_q.push_back({e[9:0], m_even, pend.size() == 0, m_rd});
        end
    endtask

    initial forever begin
        @(posedge GTX_CLK);
        model_step();
    end

    // ---------------- scoreboard ----------------
    initial forever begin
        logic [12:0] exp_v, act_v;
        @(negedge GTX_CLK);
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {tx_code_group, tx_even, TX_OSET_indicate, tx_disparity};
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL stream @%0t: got code=%b even=%b ind=%b rd=%b, want code=%b even=%b ind=%b rd=%b",
                         $time, act_v[12:3], act_v[2], act_v[1], act_v[0],
                         exp_v[12:3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic check_out(input string name, input logic [9:0] code,
                             input logic even, input logic ind, input logic rd);
        n_tests++;
        if ({tx_code_group, tx_even, TX_OSET_indicate, tx_disparity} !== {code, even, ind, rd}) begin
            n_fail++;
            $display("FAIL %s: got code=%b even=%b ind=%b rd=%b, want code=%b even=%b ind=%b rd=%b",
                     name, tx_code_group, tx_even, TX_OSET_indicate, tx_disparity, code, even, ind, rd);
        end
    endtask

    task automatic check_model(input string name, input logic [10:0] got, input logic [10:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: model gave %b, want %b", name, got, want);
        end
    endtask

    task automatic apply(input logic [2:0] oset, input logic [7:0] data);
        tx_o_set = oset;
        TXD      = data;
        @(negedge GTX_CLK);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        mr_main_reset = 1'b1;
        tx_o_set      = 3'd0;
        TXD           = 8'h00;

        check_model("enc_k28_5_rdn", model_encode(SYM_K28_5, 1'b0), {1'b1, 10'b0011111010});
        check_model("enc_d0_1_rdn",  model_encode('h20, 1'b0), {1'b1, 10'b1001111001});
        check_model("enc_d16_2_rdp", model_encode('h50, 1'b1), {1'b0, 10'b1001000101});
        check_model("enc_d17_7_a7",  model_encode('hF1, 1'b0), {1'b1, 10'b1000110111});
        check_model("enc_d11_7_a7",  model_encode('hEB, 1'b1), {1'b0, 10'b1101001000});
        check_model("enc_d0_7_p7",   model_encode('hE0, 1'b0), {1'b0, 10'b1001110001});

        repeat (3) @(negedge GTX_CLK);
        check_out("reset", 10'b0011111010, 1'b1, 1'b0, 1'b1);
        mr_main_reset = 1'b0;
        @(negedge GTX_CLK);
        check_out("post_reset", 10'b1001000101, 1'b0, 1'b1, 1'b0);

        repeat (2) begin
            @(negedge GTX_CLK);
            check_out("idle_k", 10'b0011111010, 1'b1, 1'b0, 1'b1);
            @(negedge GTX_CLK);
            check_out("idle_i2", 10'b1001000101, 1'b0, 1'b1, 1'b0);
        end

        apply(3'd2, 8'h00); check_out("start_k27_7", 10'b1101101000, 1'b1, 1'b1, 1'b0);
        apply(3'd1, 8'h00); check_out("data_d0_0",   10'b1001110100, 1'b0, 1'b1, 1'b0);
        apply(3'd3, 8'h00); check_out("term_k29_7",  10'b1011101000, 1'b1, 1'b1, 1'b0);
        apply(3'd1, 8'h20); check_out("data_d0_1",   10'b1001111001, 1'b0, 1'b1, 1'b1);
        apply(3'd0, 8'h00); check_out("idle_k_rdp",  10'b1100000101, 1'b1, 1'b0, 1'b0);
        @(negedge GTX_CLK); check_out("idle_i1",     10'b1010010110, 1'b0, 1'b1, 1'b0);
        apply(3'd7, 8'h00); check_out("oset7_k30_7", 10'b0111101000, 1'b1, 1'b1, 1'b0);
        apply(3'd0, 8'h00); check_out("align_k23_7", 10'b1110101000, 1'b0, 1'b0, 1'b0);
        @(negedge GTX_CLK); check_out("align_k28_5", 10'b0011111010, 1'b1, 1'b0, 1'b1);
        @(negedge GTX_CLK); check_out("align_i2",    10'b1001000101, 1'b0, 1'b1, 1'b0);

        // reset on the edge that would emit the idle D
        @(negedge GTX_CLK); check_out("pre_rst_k28_5", 10'b0011111010, 1'b1, 1'b0, 1'b1);
        mr_main_reset = 1'b1;
        @(negedge GTX_CLK); check_out("rst_in_idle_d", 10'b0011111010, 1'b1, 1'b0, 1'b1);
        mr_main_reset = 1'b0;
        @(negedge GTX_CLK); check_out("rst_idle_d_exit", 10'b1001000101, 1'b0, 1'b1, 1'b0);

        // reset right after the alignment pad
        apply(3'd5, 8'h00); check_out("v_k30_7",   10'b0111101000, 1'b1, 1'b1, 1'b0);
        apply(3'd0, 8'h00); check_out("align2",    10'b1110101000, 1'b0, 1'b0, 1'b0);
        mr_main_reset = 1'b1;
        @(negedge GTX_CLK); check_out("rst_in_align", 10'b0011111010, 1'b1, 1'b0, 1'b1);
        mr_main_reset = 1'b0;
        @(negedge GTX_CLK); check_out("rst_align_exit", 10'b1001000101, 1'b0, 1'b1, 1'b0);

        repeat (3000) begin
            tx_o_set      = 3'($urandom_range(0, 7));
            TXD           = 8'($urandom);
            mr_main_reset = ($urandom_range(0, 199) == 0);
            @(negedge GTX_CLK);
        end
        mr_main_reset = 1'b0;
        tx_o_set      = 3'd0;
        repeat (4) @(negedge GTX_CLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
